// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - SIMT warp scheduler with per-thread PCs, round-robin warp issue and core FSM.
// Optional build macro: MIN_PC_RECONVERGE_EN (min-PC divergence serialisation and reconvergence).
module warp_scheduler #(
  parameter int THREADS_PER_WARP = 4,
  parameter int WARPS            = 2,
  parameter int PC_BITS          = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(WARPS*THREADS_PER_WARP):0] thread_count,
  input  logic                                   fetch_done,
  input  logic                                   decoded_ret,
  input  logic [2*THREADS_PER_WARP-1:0]          lsu_state,
  input  logic [PC_BITS*THREADS_PER_WARP-1:0]    next_pc,
  output logic [2:0]                             core_state,
  output logic [PC_BITS-1:0]                     current_pc,
  output logic [$clog2(WARPS)-1:0]               active_warp,
  output logic [THREADS_PER_WARP-1:0]            thread_mask,
  output logic                                   done
);
  localparam int TPW = THREADS_PER_WARP;
  localparam int NT  = WARPS * TPW;
  localparam int WW  = $clog2(WARPS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t             r_state;
  logic [PC_BITS-1:0] r_pc [NT];
  logic [NT-1:0]      r_fin;
  logic [PC_BITS-1:0] r_cur_pc;
  logic [WW-1:0]      r_warp;
  logic [TPW-1:0]     r_mask;
  logic               r_done;

  logic [PC_BITS-1:0] w_pc_nxt [NT];
  logic [NT-1:0]      w_fin_nxt;
  logic [PC_BITS-1:0] w_wr_pc [TPW];
  logic               w_lsu_ready;
  logic               w_found;
  logic [WW-1:0]      w_sel_warp;
  logic [PC_BITS-1:0] w_sel_pc;
  logic [TPW-1:0]     w_sel_mask;

  assign core_state  = r_state;
  assign current_pc  = r_cur_pc;
  assign active_warp = r_warp;
  assign thread_mask = r_mask;
  assign done        = r_done;

  // A lane is quiescent when its LSU is idle (00) or done (11), i.e. both bits equal.
  always_comb begin
    w_lsu_ready = 1'b1;
    for (int t = 0; t < TPW; t++) begin
      if (r_mask[t] && (lsu_state[2*t] != lsu_state[2*t+1])) w_lsu_ready = 1'b0;
    end
  end

`ifdef MIN_PC_RECONVERGE_EN
  always_comb begin
    for (int t = 0; t < TPW; t++) w_wr_pc[t] = next_pc[t*PC_BITS +: PC_BITS];
  end
`else
  logic [PC_BITS-1:0] w_lead_pc;

  // Lockstep: the lowest masked lane decides the PC for the whole warp.
  always_comb begin
    w_lead_pc = next_pc[PC_BITS-1:0];
    for (int t = TPW-1; t >= 0; t--) begin
      if (r_mask[t]) w_lead_pc = next_pc[t*PC_BITS +: PC_BITS];
    end
    for (int t = 0; t < TPW; t++) w_wr_pc[t] = w_lead_pc;
  end
`endif

  always_comb begin
    w_fin_nxt = r_fin;
    for (int g = 0; g < NT; g++) w_pc_nxt[g] = r_pc[g];
    if (r_state == S_IDLE && start) begin
      for (int g = 0; g < NT; g++) begin
        w_pc_nxt[g]  = '0;
        w_fin_nxt[g] = (g >= int'(thread_count));
      end
    end else if (r_state == S_UPDATE) begin
      for (int w = 0; w < WARPS; w++) begin
        for (int t = 0; t < TPW; t++) begin
          if (WW'(w) == r_warp && r_mask[t]) begin
            if (decoded_ret) w_fin_nxt[w*TPW+t] = 1'b1;
            else             w_pc_nxt[w*TPW+t]  = w_wr_pc[t];
          end
        end
      end
    end
  end

  // Round-robin from active_warp+1 (active warp last); launch scans from warp 0.
  always_comb begin
    int base;
    int idx;
    w_found    = 1'b0;
    w_sel_warp = '0;
    base       = (r_state == S_IDLE) ? 0 : int'(r_warp) + 1;
    idx        = 0;
    for (int k = 0; k < WARPS; k++) begin
      idx = base + k;
      if (idx >= WARPS) idx = idx - WARPS;
      if (!w_found && !(&w_fin_nxt[idx*TPW +: TPW])) begin
        w_found    = 1'b1;
        w_sel_warp = WW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_mask = '0;
`ifdef MIN_PC_RECONVERGE_EN
    w_sel_pc = '1;
`else
    w_sel_pc = '0;
`endif
    for (int w = 0; w < WARPS; w++) begin
      if (WW'(w) == w_sel_warp) begin
`ifdef MIN_PC_RECONVERGE_EN
        for (int t = 0; t < TPW; t++) begin
          if (!w_fin_nxt[w*TPW+t] && (w_pc_nxt[w*TPW+t] <= w_sel_pc)) w_sel_pc = w_pc_nxt[w*TPW+t];
        end
        for (int t = 0; t < TPW; t++) begin
          w_sel_mask[t] = !w_fin_nxt[w*TPW+t] && (w_pc_nxt[w*TPW+t] == w_sel_pc);
        end
`else
        for (int t = TPW-1; t >= 0; t--) begin
          if (!w_fin_nxt[w*TPW+t]) w_sel_pc = w_pc_nxt[w*TPW+t];
        end
        for (int t = 0; t < TPW; t++) w_sel_mask[t] = !w_fin_nxt[w*TPW+t];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cur_pc <= '0;
      r_warp   <= '0;
      r_mask   <= '0;
      r_done   <= 1'b0;
      r_fin    <= '1;
      for (int g = 0; g < NT; g++) r_pc[g] <= '0;
    end else begin
      r_fin <= w_fin_nxt;
      for (int g = 0; g < NT; g++) r_pc[g] <= w_pc_nxt[g];
      case (r_state)
        S_IDLE, S_UPDATE: begin
          if (r_state == S_UPDATE || start) begin
            if (w_found) begin
              r_state  <= S_FETCH;
              r_warp   <= w_sel_warp;
              r_cur_pc <= w_sel_pc;
              r_mask   <= w_sel_mask;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_FETCH:   if (fetch_done) r_state <= S_DECODE;
        S_DECODE:  r_state <= S_REQUEST;
        S_REQUEST: r_state <= S_WAIT;
        S_WAIT:    if (w_lsu_ready) r_state <= S_EXECUTE;
        S_EXECUTE: r_state <= S_UPDATE;
        S_DONE:    r_state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - randomized self-checking bench for warp_scheduler against a thread-level model.
// Honours MIN_PC_RECONVERGE_EN to select the matching reference rules.
module tb_warp_scheduler;
  localparam int TPW   = 4;
  localparam int WARPS = 2;
  localparam int PCB   = 8;
  localparam int NT    = WARPS * TPW;
  localparam int TCW   = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [TCW-1:0]   thread_count;
  logic             fetch_done;
  logic             decoded_ret;
  logic [2*TPW-1:0] lsu_state;
  logic [PCB*TPW-1:0] next_pc;
  logic [2:0]       core_state;
  logic [PCB-1:0]   current_pc;
  logic [0:0]       active_warp;
  logic [TPW-1:0]   thread_mask;
  logic             done;

  warp_scheduler #(.THREADS_PER_WARP(TPW), .WARPS(WARPS), .PC_BITS(PCB)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .fetch_done(fetch_done), .decoded_ret(decoded_ret), .lsu_state(lsu_state),
    .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
    .active_warp(active_warp), .thread_mask(thread_mask), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Thread-level reference state
  int             m_pc [NT];
  bit             m_fin [NT];
  int             m_warp;
  int             m_tc;
  int             e_pc;
  logic [TPW-1:0] e_mask;
  bit             m_found;
  int             mode;
  int             force_busy;
  int             n_instr;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic bit warp_live(input int w);
    bit live = 0;
    for (int t = 0; t < TPW; t++) if (!m_fin[w*TPW+t]) live = 1;
    return live;
  endfunction

  task automatic model_pick(input bit from_idle);
    int w;
    m_found = 0;
    for (int k = 0; k < WARPS; k++) begin
      w = from_idle ? k : (m_warp + 1 + k) % WARPS;
      if (!m_found && warp_live(w)) begin
        m_found = 1;
        m_warp  = w;
      end
    end
    e_mask = '0;
    e_pc   = -1;
    if (!m_found) return;
`ifdef MIN_PC_RECONVERGE_EN
    for (int t = 0; t < TPW; t++)
      if (!m_fin[m_warp*TPW+t] && (e_pc < 0 || m_pc[m_warp*TPW+t] < e_pc)) e_pc = m_pc[m_warp*TPW+t];
    for (int t = 0; t < TPW; t++)
      e_mask[t] = !m_fin[m_warp*TPW+t] && (m_pc[m_warp*TPW+t] == e_pc);
`else
    for (int t = 0; t < TPW; t++) begin
      if (!m_fin[m_warp*TPW+t]) begin
        if (e_pc < 0) e_pc = m_pc[m_warp*TPW+t];
        e_mask[t] = 1'b1;
      end
    end
`endif
  endtask

  task automatic model_update(input logic ret, input logic [PCB*TPW-1:0] npc);
`ifndef MIN_PC_RECONVERGE_EN
    int lead = -1;
    for (int t = 0; t < TPW; t++) if (e_mask[t] && lead < 0) lead = t;
`endif
    for (int t = 0; t < TPW; t++) begin
      if (e_mask[t]) begin
        if (ret) m_fin[m_warp*TPW+t] = 1;
`ifdef MIN_PC_RECONVERGE_EN
        else m_pc[m_warp*TPW+t] = int'(npc[t*PCB +: PCB]);
`else
        else m_pc[m_warp*TPW+t] = int'(npc[lead*PCB +: PCB]);
`endif
      end
    end
  endtask

  task automatic gen_instr(output logic ret, output logic [PCB*TPW-1:0] npc);
    npc = '0;
    ret = 1'b0;
    case (mode)
      0: begin
        ret = (e_pc == 2);
        for (int t = 0; t < TPW; t++) npc[t*PCB +: PCB] = PCB'(e_pc + 1);
      end
      1: begin
        ret = (n_instr >= 12) || ($urandom % 4 == 0);
        for (int t = 0; t < TPW; t++) npc[t*PCB +: PCB] = PCB'($urandom);
      end
      default: begin
        ret = (m_warp != 0) || (e_pc == 7);
        for (int t = 0; t < TPW; t++)
          npc[t*PCB +: PCB] = (e_pc == 0) ? 8'd2 : (e_pc == 2) ? ((t < 2) ? 8'd3 : 8'd7) : 8'd7;
      end
    endcase
  endtask

  task automatic run_instr(input bit do_reset, output bit aborted);
    logic             ret;
    logic [PCB*TPW-1:0] npc;
    logic [2*TPW-1:0] lsu_busy;
    logic [2*TPW-1:0] lsu_idle;
    int lat;
    int busy;
    aborted = 0;
    check_eq("fetch_state", core_state, 3'd1);
    check_eq("warp", active_warp, m_warp);
    check_eq("pc", current_pc, e_pc);
    check_eq("mask", thread_mask, e_mask);
    if (mode == 0 && m_tc == 8) begin
      check_eq("seq_warp", active_warp, n_instr % 2);
      check_eq("seq_pc", current_pc, n_instr / 2);
    end
    if (mode == 2 && n_instr == 3) begin
      check_eq("rc_pc3", current_pc, 3);
      check_eq("rc_mask3", thread_mask, 4'b0011);
    end
    if (mode == 2 && n_instr == 4) begin
      check_eq("rc_pc7", current_pc, 7);
      check_eq("rc_mask7", thread_mask, 4'b1111);
    end
    lat = $urandom_range(0, 3);
    for (int i = 0; i < lat; i++) begin
      fetch_done = 1'b0;
      step();
      check_eq("fetch_hold", core_state, 3'd1);
    end
    fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    check_eq("decode", core_state, 3'd2);
    gen_instr(ret, npc);
    decoded_ret = ret;
    next_pc     = npc;
    step();
    check_eq("request", core_state, 3'd3);
    busy = (force_busy >= 0) ? force_busy : $urandom_range(0, 3);
    for (int t = 0; t < TPW; t++) begin
      if (e_mask[t]) begin
        lsu_busy[2*t +: 2] = (force_busy >= 0) ? 2'b10 : (($urandom % 2 == 1) ? 2'b01 : 2'b10);
        lsu_idle[2*t +: 2] = (force_busy >= 0 || $urandom % 2 == 1) ? 2'b11 : 2'b00;
      end else begin
        lsu_busy[2*t +: 2] = (force_busy >= 0) ? 2'b01 : 2'($urandom);
        lsu_idle[2*t +: 2] = lsu_busy[2*t +: 2];
      end
    end
    lsu_state = (busy > 0) ? lsu_busy : lsu_idle;
    step();
    check_eq("wait", core_state, 3'd4);
    if (do_reset) begin
      #1 reset = 1'b0;
      #1;
      check_eq("async_state", core_state, 3'd0);
      check_eq("async_pc", current_pc, 0);
      check_eq("async_warp", active_warp, 0);
      check_eq("async_mask", thread_mask, 0);
      check_eq("async_done", done, 0);
      step();
      lsu_state   = '0;
      decoded_ret = 1'b0;
      reset       = 1'b1;
      step();
      check_eq("post_rst_idle", core_state, 3'd0);
      aborted = 1;
      return;
    end
    for (int i = 1; i < busy; i++) begin
      step();
      check_eq("wait_hold", core_state, 3'd4);
    end
    lsu_state = lsu_idle;
    step();
    check_eq("execute", core_state, 3'd5);
    if ($urandom % 2 == 1) start = 1'b1;
    step();
    start = 1'b0;
    check_eq("update", core_state, 3'd6);
    model_update(ret, npc);
    model_pick(0);
    step();
  endtask

  task automatic run_kernel(input int tc, input int md, input int fb, input int reset_at);
    bit ab;
    mode       = md;
    force_busy = fb;
    m_tc       = tc;
    n_instr    = 0;
    check_eq("idle_state", core_state, 3'd0);
    check_eq("idle_done", done, 0);
    thread_count = TCW'(tc);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < NT; g++) begin
      m_pc[g]  = 0;
      m_fin[g] = (g >= tc);
    end
    model_pick(1);
    while (m_found && n_instr < 200) begin
      run_instr(n_instr == reset_at, ab);
      if (ab) return;
      n_instr++;
    end
    check_eq("end_state", core_state, 3'd7);
    check_eq("end_done", done, 1);
    if (mode == 0 && tc == 8) check_eq("seq_len", n_instr, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("done_hold_state", core_state, 3'd7);
    check_eq("done_hold", done, 1);
    reset = 1'b0;
    step();
    check_eq("rst_state", core_state, 3'd0);
    check_eq("rst_done", done, 0);
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    thread_count = '0;
    fetch_done   = 1'b0;
    decoded_ret  = 1'b0;
    lsu_state    = '0;
    next_pc      = '0;
    m_warp       = 0;
    step();
    step();
    check_eq("reset_state", core_state, 3'd0);
    check_eq("reset_pc", current_pc, 0);
    check_eq("reset_warp", active_warp, 0);
    check_eq("reset_mask", thread_mask, 0);
    check_eq("reset_done", done, 0);
    reset = 1'b1;
    step();
    run_kernel(8, 0, -1, -1);
    run_kernel(5, 0, -1, -1);
    run_kernel(0, 0, -1, -1);
    run_kernel(7, 1, 5, -1);
    run_kernel(8, 0, -1, 3);
    run_kernel(8, 0, -1, -1);
`ifdef MIN_PC_RECONVERGE_EN
    run_kernel(8, 2, -1, -1);
`endif
    for (int k = 0; k < 20; k++) run_kernel($urandom_range(0, 8), 1, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 SHALL have parameter THREADS_PER_WARP, default 4: lanes sharing one fetch/decode per instruction.
REQ-002 SHALL have parameter WARPS, default 2 (legal >=2): warps per core, interleaved per instruction.
REQ-003 SHALL have parameter PC_BITS, default 8: program counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  kernel launch pulse, honoured only in IDLE.
REQ-007 SHALL have port thread_count  input  $clog2(WARPS*THREADS_PER_WARP)+1  enabled threads, sampled at start.
REQ-008 SHALL have port fetch_done  input  1  fetcher holds instruction for current_pc.
REQ-009 SHALL have port decoded_ret  input  1  decoded instruction is RET.
REQ-010 SHALL have port lsu_state  input  2*THREADS_PER_WARP  per-lane LSU state (00 idle, 01 requesting, 10 waiting, 11 done).
REQ-011 SHALL have port next_pc  input  PC_BITS*THREADS_PER_WARP  per-lane next PC of active warp, lane 0 in LSBs.
REQ-012 SHALL have port core_state  output  3  IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111.
REQ-013 SHALL have port current_pc  output  PC_BITS  PC being fetched/executed for active warp.
REQ-014 SHALL have port active_warp  output  $clog2(WARPS)  warp owning the pipeline.
REQ-015 SHALL have port thread_mask  output  THREADS_PER_WARP  lanes executing current instruction.
REQ-016 SHALL have port done  output  1  kernel complete.

Function
REQ-017 SHALL enable global thread w*THREADS_PER_WARP+t iff it is < latched thread_count; disabled threads never appear in thread_mask.
REQ-018 SHALL hold per-thread PC (reset to 0 at start) and per-thread finished flag (disabled threads start finished).
REQ-019 SHALL in IDLE with start=1: latch thread_count, clear PCs, select lowest-index warp with an unfinished thread, go FETCH; if none (thread_count=0) go DONE.
REQ-020 SHALL stay in FETCH until fetch_done=1, then go DECODE.
REQ-021 SHALL spend exactly one cycle each in DECODE, REQUEST, EXECUTE, UPDATE.
REQ-022 SHALL stay in WAIT (minimum one cycle) until every masked lane's lsu_state is 00 or 11; unmasked lanes ignored.
REQ-023 SHALL in UPDATE copy next_pc into PC of each masked lane; if decoded_ret=1, set finished flag of masked lanes instead (PC unchanged).
REQ-024 SHALL after UPDATE select next warp round-robin from active_warp+1 (wrapping, active warp considered last) having any unfinished thread; go FETCH, else DONE.
REQ-025 SHALL on entry to FETCH register current_pc and thread_mask for the selected warp; both stable until next FETCH entry.
REQ-026 SHALL, with reconvergence compiled in, set current_pc = minimum PC of unfinished threads of that warp, thread_mask = unfinished threads whose PC equals it (ties by unsigned compare).
REQ-027 SHALL assert done=1 only in DONE; DONE held until reset; start ignored outside IDLE.
REQ-028 SHALL treat next_pc as unsigned PC_BITS; wrap-around from max to 0 is accepted without detection.

Reset
REQ-029 SHALL on reset=0, immediately and regardless of state: core_state=IDLE, current_pc=0, active_warp=0, thread_mask=0, done=0, all PCs 0, all finished flags set.
REQ-030 SHALL resume normal operation on first rising clk edge after reset deasserts, waiting for start.

Configuration
REQ-031 SHALL with MIN_PC_RECONVERGE_EN defined implement REQ-026 (divergent lanes serialised, reconverge at common PC).
REQ-032 SHALL without MIN_PC_RECONVERGE_EN use PC of lowest-index unfinished thread as current_pc, mask = all unfinished threads, and write lane-0-of-mask next_pc to all masked lanes (lockstep, divergence unsupported).

Verification
REQ-033 SHALL cover: thread_count=8, each instruction fetch_done next cycle, RET at PC 2 -> warps alternate 0,1,0,...; done after 6 instructions; PCs 0,0,1,1,2,2.
REQ-034 SHALL cover: thread_count=5 -> warp 1 mask=0001; thread_count=0 -> IDLE->DONE in one cycle.
REQ-035 SHALL cover (EN defined): warp 0 next_pc lanes={3,3,7,7} from PC 2 -> next warp-0 fetch PC 3 mask 0011; after lanes 0-1 reach 7, PC 7 mask 1111.
REQ-036 SHALL cover: masked lane 2 lsu_state=10 for 5 cycles, unmasked lane 3 stuck 01 -> WAIT exits 1 cycle after lane 2 reaches 11.
REQ-037 SHALL cover: reset=0 asserted in WAIT mid-edge -> all outputs at reset values before next clk edge; start after release runs kernel from PC 0.
REQ-038 SHALL cover: start pulsed during EXECUTE and in DONE -> no effect; done stays 1.
